// File: rtl/mem_axi_bist.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mem_axi_bist                                                 |
// | Description : AXI4 initiator memory self-test. Writes a data pattern over  |
// |               a word range in INCR bursts, reads it back, compares and     |
// |               reports pass/fail, error count and first failing address.    |
// | Option      : MEM_BIST_INVERT_PASS_EN - adds a second write+read pass      |
// |               using the bit-inverted pattern; errors accumulate.           |
// | Ports       : clk_i/rst_n_i   clock, asynchronous active-low reset         |
// |               start_i         one-cycle start pulse (ignored when busy)    |
// |               pattern_i       0 all-0, 1 all-1, 2 55/AA by word, 3 index   |
// |               busy_o/done_o   test running / one-cycle end pulse           |
// |               pass_o          no errors at end, held until next start      |
// |               err_cnt_o       saturating error count                       |
// |               fail_addr_o     byte address of first failure, 0 if none     |
// |               axi_*           AXI4 master AW/W/B/AR/R channels             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mem_axi_bist #(
   parameter logic [31:0] BASE_ADDR  = 32'h0,
   parameter int          MEM_WORDS  = 1024,
   parameter int          BURST_LEN  = 16,
   parameter int          DATA_WIDTH = 32,
   parameter int          ID_WIDTH   = 4,
   parameter logic [ID_WIDTH-1:0] AXI_ID = '0
) (
   input  logic                    clk_i,
   input  logic                    rst_n_i,
   input  logic                    start_i,
   input  logic [1:0]              pattern_i,
   output logic                    busy_o,
   output logic                    done_o,
   output logic                    pass_o,
   output logic [15:0]             err_cnt_o,
   output logic [31:0]             fail_addr_o,
   // write address
   output logic [ID_WIDTH-1:0]     axi_awid_o,
   output logic [31:0]             axi_awaddr_o,
   output logic [7:0]              axi_awlen_o,
   output logic [2:0]              axi_awsize_o,
   output logic [1:0]              axi_awburst_o,
   output logic                    axi_awvalid_o,
   input  logic                    axi_awready_i,
   // write data
   output logic [DATA_WIDTH-1:0]   axi_wdata_o,
   output logic [DATA_WIDTH/8-1:0] axi_wstrb_o,
   output logic                    axi_wlast_o,
   output logic                    axi_wvalid_o,
   input  logic                    axi_wready_i,
   // write response
   input  logic [1:0]              axi_bresp_i,
   input  logic                    axi_bvalid_i,
   output logic                    axi_bready_o,
   // read address
   output logic [ID_WIDTH-1:0]     axi_arid_o,
   output logic [31:0]             axi_araddr_o,
   output logic [7:0]              axi_arlen_o,
   output logic [2:0]              axi_arsize_o,
   output logic [1:0]              axi_arburst_o,
   output logic                    axi_arvalid_o,
   input  logic                    axi_arready_i,
   // read data
   input  logic [DATA_WIDTH-1:0]   axi_rdata_i,
   input  logic [1:0]              axi_rresp_i,
   input  logic                    axi_rlast_i,
   input  logic                    axi_rvalid_i,
   output logic                    axi_rready_o
);

   localparam int          BYTES       = DATA_WIDTH / 8;
   localparam int          NBURSTS     = MEM_WORDS / BURST_LEN;
   localparam logic [31:0] C_BYTES     = 32'(BYTES);
   localparam logic [31:0] C_BLEN      = 32'(BURST_LEN);
   localparam logic [31:0] C_WORDS     = 32'(MEM_WORDS);
   localparam logic [31:0] C_BURST_B   = 32'(BURST_LEN * BYTES);
   localparam logic [31:0] C_LAST_BEAT = 32'(BURST_LEN - 1);
   localparam logic [31:0] C_LAST_BRST = 32'(NBURSTS - 1);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_WR_ADDR = 3'd1;
   localparam logic [2:0] S_WR_DATA = 3'd2;
   localparam logic [2:0] S_WR_RESP = 3'd3;
   localparam logic [2:0] S_RD_ADDR = 3'd4;
   localparam logic [2:0] S_RD_DATA = 3'd5;
   localparam logic [2:0] S_DONE    = 3'd6;

   logic [2:0]            r_state;
   logic [2:0]            w_state_nxt;
   logic [1:0]            r_pattern;
   logic [31:0]           r_burst;
   logic [31:0]           r_beat;
   logic                  r_len_err;
   logic [15:0]           r_err_cnt;
   logic [31:0]           r_fail_addr;
   logic                  r_pass;
`ifdef MEM_BIST_INVERT_PASS_EN
   logic                  r_inv;
`endif

   logic                  w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
   logic                  w_beat_last, w_burst_last;
   logic [31:0]           w_idx_raw, w_word_idx;
   logic [31:0]           w_burst_addr, w_beat_addr, w_err_addr;
   logic [DATA_WIDTH-1:0] w_pat, w_exp;
   logic                  w_beat_err, w_len_err, w_b_err;
   logic [1:0]            w_err_inc;
   logic [16:0]           w_err_sum;
   logic [15:0]           w_err_next;

   // Handshakes are decoded from the state so they always agree with the
   // valid/ready values actually driven on the ports.
   assign w_aw_hs      = (r_state == S_WR_ADDR) && axi_awready_i;
   assign w_w_hs       = (r_state == S_WR_DATA) && axi_wready_i;
   assign w_b_hs       = (r_state == S_WR_RESP) && axi_bvalid_i;
   assign w_ar_hs      = (r_state == S_RD_ADDR) && axi_arready_i;
   assign w_r_hs       = (r_state == S_RD_DATA) && axi_rvalid_i;
   assign w_beat_last  = (r_beat == C_LAST_BEAT);
   assign w_burst_last = (r_burst == C_LAST_BRST);

   // Word index only exceeds the range when a slave overruns the last burst
   // (late RLAST), so a single conditional subtract implements the wrap.
   assign w_idx_raw    = r_burst * C_BLEN + r_beat;
   assign w_word_idx   = (w_idx_raw >= C_WORDS) ? (w_idx_raw - C_WORDS) : w_idx_raw;
   assign w_burst_addr = BASE_ADDR + r_burst * C_BURST_B;
   assign w_beat_addr  = BASE_ADDR + w_word_idx * C_BYTES;

   always_comb begin
      w_pat = '0;
      case (r_pattern)
         2'd0:    w_pat = '0;
         2'd1:    w_pat = '1;
         2'd2:    w_pat = w_word_idx[0] ? {BYTES{8'hAA}} : {BYTES{8'h55}};
         default: w_pat = DATA_WIDTH'(w_word_idx);
      endcase
   end

`ifdef MEM_BIST_INVERT_PASS_EN
   assign w_exp = r_inv ? ~w_pat : w_pat;
`else
   assign w_exp = w_pat;
`endif

   // Error sources. A burst length violation is counted once per burst,
   // independent of any data/response error on the same beat.
   assign w_beat_err = w_r_hs && ((axi_rdata_i != w_exp) || (axi_rresp_i != 2'b00));
   assign w_len_err  = w_r_hs && !r_len_err && (axi_rlast_i != w_beat_last);
   assign w_b_err    = w_b_hs && (axi_bresp_i != 2'b00);
   assign w_err_inc  = {1'b0, w_beat_err} + {1'b0, w_len_err} + {1'b0, w_b_err};
   assign w_err_sum  = {1'b0, r_err_cnt} + {15'd0, w_err_inc};
   assign w_err_next = w_err_sum[16] ? 16'hFFFF : w_err_sum[15:0];
   assign w_err_addr = (r_state == S_WR_RESP) ? w_burst_addr : w_beat_addr;

   // ---------------------------------------------------------------- state reg
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   // ---------------------------------------------------------------- next state
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:    if (start_i) w_state_nxt = S_WR_ADDR;
         S_WR_ADDR: if (w_aw_hs) w_state_nxt = S_WR_DATA;
         S_WR_DATA: if (w_w_hs && w_beat_last) w_state_nxt = S_WR_RESP;
         S_WR_RESP: if (w_b_hs) w_state_nxt = w_burst_last ? S_RD_ADDR : S_WR_ADDR;
         S_RD_ADDR: if (w_ar_hs) w_state_nxt = S_RD_DATA;
         S_RD_DATA: begin
            if (w_r_hs && axi_rlast_i) begin
               if (!w_burst_last) begin
                  w_state_nxt = S_RD_ADDR;
               end else begin
`ifdef MEM_BIST_INVERT_PASS_EN
                  w_state_nxt = r_inv ? S_DONE : S_WR_ADDR;
`else
                  w_state_nxt = S_DONE;
`endif
               end
            end
         end
         S_DONE:    w_state_nxt = S_IDLE;
         default:   w_state_nxt = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------- outputs
   always_comb begin
      axi_awvalid_o = (r_state == S_WR_ADDR);
      axi_wvalid_o  = (r_state == S_WR_DATA);
      axi_bready_o  = (r_state == S_WR_RESP);
      axi_arvalid_o = (r_state == S_RD_ADDR);
      axi_rready_o  = (r_state == S_RD_DATA);
      busy_o        = (r_state != S_IDLE) && (r_state != S_DONE);
      done_o        = (r_state == S_DONE);
   end

   assign axi_awid_o    = AXI_ID;
   assign axi_awaddr_o  = w_burst_addr;
   assign axi_awlen_o   = 8'(BURST_LEN - 1);
   assign axi_awsize_o  = 3'($clog2(BYTES));
   assign axi_awburst_o = 2'b01;
   assign axi_arid_o    = AXI_ID;
   assign axi_araddr_o  = w_burst_addr;
   assign axi_arlen_o   = 8'(BURST_LEN - 1);
   assign axi_arsize_o  = 3'($clog2(BYTES));
   assign axi_arburst_o = 2'b01;
   assign axi_wdata_o   = w_exp;
   assign axi_wstrb_o   = '1;
   assign axi_wlast_o   = w_beat_last;

   assign pass_o        = r_pass;
   assign err_cnt_o     = r_err_cnt;
   assign fail_addr_o   = r_fail_addr;

   // ---------------------------------------------------------------- datapath
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_pattern   <= 2'd0;
         r_burst     <= '0;
         r_beat      <= '0;
         r_len_err   <= 1'b0;
         r_err_cnt   <= 16'd0;
         r_fail_addr <= 32'd0;
         r_pass      <= 1'b0;
`ifdef MEM_BIST_INVERT_PASS_EN
         r_inv       <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start_i) begin
                  r_pattern   <= pattern_i;
                  r_burst     <= '0;
                  r_beat      <= '0;
                  r_len_err   <= 1'b0;
                  r_err_cnt   <= 16'd0;
                  r_fail_addr <= 32'd0;
                  r_pass      <= 1'b0;
`ifdef MEM_BIST_INVERT_PASS_EN
                  r_inv       <= 1'b0;
`endif
               end
            end
            S_WR_DATA: begin
               if (w_w_hs) r_beat <= w_beat_last ? '0 : r_beat + 32'd1;
            end
            S_WR_RESP: begin
               if (w_b_hs) r_burst <= w_burst_last ? '0 : r_burst + 32'd1;
            end
            S_RD_DATA: begin
               if (w_r_hs) begin
                  if (w_len_err) r_len_err <= 1'b1;
                  if (axi_rlast_i) begin
                     r_beat    <= '0;
                     r_len_err <= 1'b0;
                     r_burst   <= w_burst_last ? '0 : r_burst + 32'd1;
`ifdef MEM_BIST_INVERT_PASS_EN
                     if (w_burst_last) r_inv <= 1'b1;
`endif
                  end else begin
                     r_beat <= r_beat + 32'd1;
                  end
               end
            end
            default: ;
         endcase

         if (w_err_inc != 2'd0) begin
            r_err_cnt <= w_err_next;
            if (r_err_cnt == 16'd0) r_fail_addr <= w_err_addr;
         end

         // Pass is resolved on entry to DONE so it is valid with done_o and
         // includes any error on the final beat.
         if ((r_state == S_RD_DATA) && (w_state_nxt == S_DONE))
            r_pass <= (w_err_next == 16'd0);
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_axi_bist.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mem_axi_bist                                              |
// | Description : Self-checking bench for mem_axi_bist with a behavioural AXI4 |
// |               slave (64-word memory, optional stalls and read faults).     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_mem_axi_bist;

`ifdef MEM_BIST_INVERT_PASS_EN
   localparam int PASSES = 2;
`else
   localparam int PASSES = 1;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [1:0]  pat;
   logic        busy, done, pass;
   logic [15:0] err_cnt;
   logic [31:0] fail_addr;
   logic [3:0]  awid, arid;
   logic [31:0] awaddr, araddr;
   logic [7:0]  awlen, arlen;
   logic [2:0]  awsize, arsize;
   logic [1:0]  awburst, arburst;
   logic        awvalid, awready, wvalid, wready, wlast;
   logic [31:0] wdata, rdata;
   logic [3:0]  wstrb;
   logic [1:0]  bresp, rresp;
   logic        bvalid, bready, arvalid, arready, rvalid, rready, rlast;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   mem_axi_bist #(
      .BASE_ADDR(32'h0), .MEM_WORDS(64), .BURST_LEN(16), .DATA_WIDTH(32),
      .ID_WIDTH(4), .AXI_ID(4'h0)
   ) dut (
      .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .pattern_i(pat),
      .busy_o(busy), .done_o(done), .pass_o(pass), .err_cnt_o(err_cnt),
      .fail_addr_o(fail_addr),
      .axi_awid_o(awid), .axi_awaddr_o(awaddr), .axi_awlen_o(awlen),
      .axi_awsize_o(awsize), .axi_awburst_o(awburst), .axi_awvalid_o(awvalid),
      .axi_awready_i(awready),
      .axi_wdata_o(wdata), .axi_wstrb_o(wstrb), .axi_wlast_o(wlast),
      .axi_wvalid_o(wvalid), .axi_wready_i(wready),
      .axi_bresp_i(bresp), .axi_bvalid_i(bvalid), .axi_bready_o(bready),
      .axi_arid_o(arid), .axi_araddr_o(araddr), .axi_arlen_o(arlen),
      .axi_arsize_o(arsize), .axi_arburst_o(arburst), .axi_arvalid_o(arvalid),
      .axi_arready_i(arready),
      .axi_rdata_i(rdata), .axi_rresp_i(rresp), .axi_rlast_i(rlast),
      .axi_rvalid_i(rvalid), .axi_rready_o(rready)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] exp_word(input logic [1:0] p, input int idx, input bit inv);
      logic [31:0] w;
      case (p)
         2'd0:    w = 32'h0000_0000;
         2'd1:    w = 32'hFFFF_FFFF;
         2'd2:    w = (idx % 2 == 0) ? 32'h5555_5555 : 32'hAAAA_AAAA;
         default: w = 32'(idx);
      endcase
      return inv ? ~w : w;
   endfunction

   // ------------------------------------------------------------ slave model
   logic [31:0] mem [0:63];
   logic [1:0]  cur_pat;
   bit          stall_en, flip5, slverr, early_last;
   int          aw_cnt = 0, ar_cnt = 0, aw_base = 0, ar_base = 0;
   logic        s_w_act, s_r_act;
   int          s_wbeat, s_rbeat, s_wburst;
   logic [31:0] s_waddr, s_raddr;
   logic        p_awv, p_awr, p_wv, p_wr, p_arv, p_arr, p_wlast;
   logic [31:0] p_awaddr, p_araddr, p_wdata;
   int          ridx;

   function automatic logic rnd_rdy(input bit en);
      return en ? 1'($urandom_range(0, 1)) : 1'b1;
   endfunction

   always_comb begin
      ridx  = int'(s_raddr >> 2) + s_rbeat;
      rdata = (ridx < 64) ? mem[ridx[5:0]] : 32'h0;
      if (flip5 && ridx == 5) rdata = rdata ^ 32'h1;
      rresp = slverr ? 2'b10 : 2'b00;
      rlast = early_last ? (s_rbeat == 14) : (s_rbeat == 15);
   end
   assign bresp = 2'b00;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         awready <= 1'b0; wready <= 1'b0; arready <= 1'b0;
         bvalid  <= 1'b0; rvalid <= 1'b0;
         s_w_act <= 1'b0; s_r_act <= 1'b0;
         s_wbeat <= 0; s_rbeat <= 0; s_wburst <= 0;
         s_waddr <= 32'h0; s_raddr <= 32'h0;
         p_awv <= 1'b0; p_wv <= 1'b0; p_arv <= 1'b0;
         p_awr <= 1'b0; p_wr <= 1'b0; p_arr <= 1'b0;
      end else begin : b_slave
         int idx;
         awready <= rnd_rdy(stall_en);
         wready  <= rnd_rdy(stall_en);
         arready <= rnd_rdy(stall_en);

         // stability of valid payloads while not accepted
         if (p_awv && !p_awr) chk("aw_stable", {31'd0, awvalid, awaddr}, {31'd0, 1'b1, p_awaddr});
         if (p_arv && !p_arr) chk("ar_stable", {31'd0, arvalid, araddr}, {31'd0, 1'b1, p_araddr});
         if (p_wv && !p_wr)   chk("w_stable", {30'd0, wvalid, wlast, wdata}, {30'd0, 1'b1, p_wlast, p_wdata});
         p_awv <= awvalid; p_awr <= awready; p_awaddr <= awaddr;
         p_arv <= arvalid; p_arr <= arready; p_araddr <= araddr;
         p_wv  <= wvalid;  p_wr  <= wready;  p_wdata  <= wdata; p_wlast <= wlast;

         if (awvalid && awready) begin
            chk("awaddr", 64'(awaddr), 64'(((aw_cnt - aw_base) % 4) * 64));
            chk("aw_fields", {49'd0, awid, awlen, awsize, awburst}, {49'd0, 4'h0, 8'd15, 3'd2, 2'd1});
            s_waddr <= awaddr; s_wburst <= aw_cnt - aw_base;
            aw_cnt <= aw_cnt + 1; s_w_act <= 1'b1; s_wbeat <= 0;
         end
         if (!s_w_act) chk("w_before_aw", 64'(wvalid), 64'd0);
         if (wvalid && wready && s_w_act) begin
            idx = int'(s_waddr >> 2) + s_wbeat;
            chk("wdata", 64'(wdata), 64'(exp_word(cur_pat, idx, s_wburst >= 4)));
            chk("wlast", 64'(wlast), 64'(s_wbeat == 15));
            chk("wstrb", 64'(wstrb), 64'hF);
            mem[idx[5:0]] <= wdata;
            s_wbeat <= s_wbeat + 1;
            if (s_wbeat == 15) begin s_w_act <= 1'b0; bvalid <= 1'b1; end
         end
         if (bvalid && bready) bvalid <= 1'b0;

         if (arvalid && arready) begin
            chk("araddr", 64'(araddr), 64'(((ar_cnt - ar_base) % 4) * 64));
            chk("ar_fields", {49'd0, arid, arlen, arsize, arburst}, {49'd0, 4'h0, 8'd15, 3'd2, 2'd1});
            s_raddr <= araddr; ar_cnt <= ar_cnt + 1; s_r_act <= 1'b1; s_rbeat <= 0;
         end
         if (rvalid && rready) begin
            if (rlast) begin
               s_r_act <= 1'b0; rvalid <= 1'b0;
            end else begin
               s_rbeat <= s_rbeat + 1; rvalid <= rnd_rdy(stall_en);
            end
         end else if (!rvalid && s_r_act) begin
            rvalid <= rnd_rdy(stall_en);
         end
      end
   end

   // ------------------------------------------------------------ vectors
   typedef struct {
      logic [1:0]  pat;
      bit          flip5;
      bit          slverr;
      bit          early;
      bit          stall;
      int          exp_err;
      logic [31:0] exp_fail;
      bit          exp_pass;
   } vec_t;

   localparam int NV = 7;
   vec_t vecs [NV];

   task automatic cfg(input vec_t v);
      cur_pat = v.pat; flip5 = v.flip5; slverr = v.slverr;
      early_last = v.early; stall_en = v.stall;
   endtask

   task automatic run_test(input vec_t v, input bit poke_busy, input bit poke_done);
      int cyc;
      int bad;
      cfg(v);
      aw_base = aw_cnt; ar_base = ar_cnt;
      @(negedge clk); start = 1'b1; pat = v.pat;
      @(negedge clk); start = 1'b0; pat = ~v.pat;
      chk("busy_after_start", 64'(busy), 64'd1);
      chk("cleared_after_start", {15'd0, pass, err_cnt, fail_addr}, 64'd0);
      if (poke_busy) begin
         repeat (5) @(negedge clk);
         start = 1'b1; pat = 2'd0;
         @(negedge clk); start = 1'b0;
      end
      cyc = 0;
      while (!done && cyc < 20000) begin @(negedge clk); cyc++; end
      chk("done_seen", 64'(done), 64'd1);
      if (done) begin
         chk("busy_in_done", 64'(busy), 64'd0);
         chk("err_cnt", 64'(err_cnt), 64'(v.exp_err));
         chk("fail_addr", 64'(fail_addr), 64'(v.exp_fail));
         chk("pass", 64'(pass), 64'(v.exp_pass));
         if (poke_done) start = 1'b1;
         @(negedge clk); start = 1'b0;
         chk("done_one_cycle", 64'(done), 64'd0);
         chk("pass_held", 64'(pass), 64'(v.exp_pass));
         @(negedge clk);
         chk("idle_busy", 64'(busy), 64'd0);
      end
      bad = 0;
      for (int i = 0; i < 64; i++)
         if (mem[i] !== exp_word(v.pat, i, PASSES == 2)) bad++;
      chk("mem_contents_bad_words", 64'(bad), 64'd0);
      chk("aw_bursts", 64'(aw_cnt - aw_base), 64'(4 * PASSES));
      chk("ar_bursts", 64'(ar_cnt - ar_base), 64'(4 * PASSES));
   endtask

   initial begin : watchdog
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : main
      int cyc;
      vec_t va;
      //             pat  flip slv early stall err          fail       pass
      vecs[0] = '{2'd3, 0, 0, 0, 0, 0,          32'h00, 1};
      vecs[1] = '{2'd0, 1, 0, 0, 0, 1 * PASSES, 32'h14, 0};
      vecs[2] = '{2'd1, 0, 1, 0, 0, 64 * PASSES, 32'h00, 0};
      vecs[3] = '{2'd2, 0, 0, 0, 1, 0,          32'h00, 1};
      vecs[4] = '{2'd3, 0, 0, 1, 1, 4 * PASSES, 32'h38, 0};
      vecs[5] = '{2'd0, 1, 0, 0, 1, 1 * PASSES, 32'h14, 0};
      vecs[6] = '{2'd1, 0, 0, 0, 1, 0,          32'h00, 1};

      rst_n = 1'b0; start = 1'b0; pat = 2'd0;
      cfg(vecs[0]);
      repeat (3) @(negedge clk);
      chk("rst_status", {12'd0, busy, done, pass, err_cnt, fail_addr}, 64'd0);
      chk("rst_axi_valid_ready", {59'd0, awvalid, wvalid, bready, arvalid, rready}, 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < NV; i++) run_test(vecs[i], 1'b0, i == NV - 1);

      // abort in the middle of a read burst with errors already counted
      va = '{2'd1, 0, 1, 0, 0, 0, 32'h0, 0};
      cfg(va);
      aw_base = aw_cnt; ar_base = ar_cnt;
      @(negedge clk); start = 1'b1; pat = 2'd1;
      @(negedge clk); start = 1'b0;
      cyc = 0;
      while (!(rready && err_cnt > 16'd2) && cyc < 5000) begin @(negedge clk); cyc++; end
      chk("reached_rd_data", 64'(rready), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("midrst_status", {12'd0, busy, done, pass, err_cnt, fail_addr}, 64'd0);
      chk("midrst_axi", {59'd0, awvalid, wvalid, bready, arvalid, rready}, 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_idle", 64'(busy), 64'd0);
      va = '{2'd3, 0, 0, 0, 0, 0, 32'h0, 1};
      run_test(va, 1'b1, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
